// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures receiver words on rx_done into a DEPTH-entry FIFO, show-ahead read port.
// Latency: a word written in cycle N is visible on rd_data/rd_valid in cycle N+1 (no empty bypass).
// Backpressure: rd_ready stalls the head; a write into a full FIFO without a same-cycle pop is dropped and sets overflow.
// Optional macro UART_RX_FIFO_ERR_COUNT_EN adds a saturating framing-error counter on err_count.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_done,
    input  logic                     rx_framing_error,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    output logic [7:0]               err_count,
`endif
    input  logic                     clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;

    logic is_full, is_empty, pop, wr_en, drop;

    always_comb begin
        is_empty   = (count_q == '0);
        is_full    = (count_q == CW'(DEPTH));
        pop        = !is_empty && rd_ready;
        // A pop frees the slot this same cycle, so a full FIFO can still accept a write.
        wr_en      = !reset && rx_done && (!is_full || pop);
        drop       = rx_done && is_full && !pop;

        wptr_d     = wr_en ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
        count_d    = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (drop)
            overflow_d = 1'b1;
        else if (clear_overflow)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem_q[wptr_q] <= rx_data;
    end

    assign rd_data  = is_empty ? '0 : mem_q[rptr_q];
    assign rd_valid = !is_empty;
    assign count    = count_q;
    assign full     = is_full;
    assign empty    = is_empty;
    assign overflow = overflow_q;

`ifdef UART_RX_FIFO_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;
    logic       err_seen_q, err_seen_d;
    logic       err_event;

    always_comb begin
        err_event   = rx_framing_error && !err_seen_q;
        err_count_d = err_count_q;
        if (clear_overflow)
            err_count_d = err_event ? 8'd1 : 8'd0;
        else if (err_event && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
        // One count per errored frame; the next received word re-arms detection.
        err_seen_d = err_seen_q;
        if (err_event)
            err_seen_d = 1'b1;
        else if (rx_done)
            err_seen_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_count_q <= 8'd0;
            err_seen_q  <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            err_seen_q  <= err_seen_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_framing_error;
    assign unused_framing_error = rx_framing_error;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 9;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] rx_data;
    logic             rx_done;
    logic             rx_framing_error;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [3:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             clear_overflow;
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    logic [7:0]       err_count;
`endif

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_done          (rx_done),
        .rx_framing_error (rx_framing_error),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .overflow         (overflow),
`ifdef UART_RX_FIFO_ERR_COUNT_EN
        .err_count        (err_count),
`endif
        .clear_overflow   (clear_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    int               m_errc;
    bit               m_errseen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs after the edge.
    task automatic step(input bit rst, input bit done, input logic [WIDTH-1:0] d,
                        input bit rdy, input bit clr, input bit ferr, input string tag);
        bit m_pop, m_full, m_wr, m_drop, m_ev;
        reset            = rst;
        rx_done          = done;
        rx_data          = d;
        rd_ready         = rdy;
        clear_overflow   = clr;
        rx_framing_error = ferr;
        if (rst) begin
            q.delete();
            m_ovf     = 0;
            m_errc    = 0;
            m_errseen = 0;
        end else begin
            m_full = (q.size() == DEPTH);
            m_pop  = (q.size() != 0) && rdy;
            m_wr   = done && (!m_full || m_pop);
            m_drop = done && m_full && !m_pop;
            if (m_pop) void'(q.pop_front());
            if (m_wr)  q.push_back(d);
            if (m_drop)     m_ovf = 1;
            else if (clr)   m_ovf = 0;
            m_ev = ferr && !m_errseen;
            if (clr)                     m_errc = m_ev ? 1 : 0;
            else if (m_ev && m_errc < 255) m_errc++;
            if (m_ev)       m_errseen = 1;
            else if (done)  m_errseen = 0;
        end
        @(posedge clock);
        #1;
        chk({tag, ".count"},    32'(count),    32'(q.size()));
        chk({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
        chk({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
        chk({tag, ".rd_data"},  32'(rd_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_ERR_COUNT_EN
        chk({tag, ".err_count"}, 32'(err_count), 32'(m_errc));
`endif
    endtask

    bit               r_done, r_rdy, r_clr;
    logic [WIDTH-1:0] r_d;

    initial begin
        reset = 1'b1; rx_done = 1'b0; rx_data = '0; rd_ready = 1'b0;
        clear_overflow = 1'b0; rx_framing_error = 1'b0;

        step(1, 0, 9'h000, 0, 0, 0, "reset");
        step(1, 0, 9'h000, 0, 0, 0, "reset");
        step(0, 0, 9'h000, 0, 0, 0, "idle");

        // Three writes held, then drained in order
        step(0, 1, 9'h1A5, 0, 0, 0, "t1.wr");
        step(0, 1, 9'h0FF, 0, 0, 0, "t1.wr");
        step(0, 1, 9'h100, 0, 0, 0, "t1.wr");
        chk("t1.count3", 32'(count), 32'd3);
        chk("t1.head", 32'(rd_data), 32'h1A5);
        for (int i = 0; i < 3; i++) step(0, 0, 9'h000, 1, 0, 0, "t1.pop");
        chk("t1.empty_after", 32'(empty), 32'd1);
        chk("t1.data0_after", 32'(rd_data), 32'd0);

        // Fill, overflow on a 9th word, drain, then clear
        for (int i = 0; i < DEPTH; i++) step(0, 1, 9'(i), 0, 0, 0, "t2.fill");
        chk("t2.full", 32'(full), 32'd1);
        step(0, 1, 9'h1FF, 0, 0, 0, "t2.drop");
        chk("t2.overflow", 32'(overflow), 32'd1);
        chk("t2.count_kept", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2.drain_order", 32'(rd_data), 32'(i));
            step(0, 0, 9'h000, 1, 0, 0, "t2.drain");
        end
        chk("t2.ovf_sticky", 32'(overflow), 32'd1);
        step(0, 0, 9'h000, 0, 1, 0, "t2.clear");
        chk("t2.ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous write and pop
        for (int i = 0; i < DEPTH; i++) step(0, 1, 9'(9'h20 + i), 0, 0, 0, "t3.fill");
        step(0, 1, 9'h155, 1, 0, 0, "t3.wr_pop");
        chk("t3.count", 32'(count), 32'(DEPTH));
        chk("t3.no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 9'h000, 1, 0, 0, "t3.drain");

        // Write+pop at count==1 hands the head to the new word
        step(0, 1, 9'h0AA, 0, 0, 0, "t3b.wr");
        step(0, 1, 9'h0BB, 1, 0, 0, "t3b.wr_pop");
        chk("t3b.head", 32'(rd_data), 32'h0BB);
        step(0, 0, 9'h000, 1, 0, 0, "t3b.pop");
        step(0, 0, 9'h000, 1, 0, 0, "t3b.pop_empty");

        // Wrap-around with occupancy kept within 0..3
        for (int i = 0; i < 40; i++) begin
            r_done = 1'($urandom_range(0, 1));
            r_rdy  = (q.size() >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            r_d    = 9'($urandom);
            step(0, r_done, r_d, r_rdy, 0, 0, "t4.wrap");
        end

        // Unconstrained random traffic, including overflow and clears
        for (int i = 0; i < 300; i++) begin
            r_done = ($urandom_range(0, 3) != 0);
            r_rdy  = ($urandom_range(0, 2) == 0);
            r_clr  = ($urandom_range(0, 15) == 0);
            r_d    = 9'($urandom);
            step(0, r_done, r_d, r_rdy, r_clr, 0, "rand");
        end
        step(0, 0, 9'h000, 0, 1, 0, "rand.clear");

        // Reset mid-operation with a concurrent rx_done
        while (q.size() > 0) step(0, 0, 9'h000, 1, 0, 0, "t5.drain");
        for (int i = 0; i < 5; i++) step(0, 1, 9'(9'h40 + i), 0, 0, 0, "t5.fill");
        chk("t5.count5", 32'(count), 32'd5);
        step(1, 1, 9'h1EE, 0, 0, 0, "t5.reset");
        chk("t5.count0", 32'(count), 32'd0);
        step(0, 0, 9'h000, 1, 0, 0, "t5.after");
        chk("t5.still_empty", 32'(empty), 32'd1);

`ifdef UART_RX_FIFO_ERR_COUNT_EN
        for (int i = 0; i < 4; i++) step(0, 0, 9'h000, 1, 0, 1, "t6.burst1");
        chk("t6.err1", 32'(err_count), 32'd1);
        step(0, 1, 9'h011, 1, 0, 0, "t6.frame");
        for (int i = 0; i < 3; i++) step(0, 0, 9'h000, 1, 0, 1, "t6.burst2");
        chk("t6.err2", 32'(err_count), 32'd2);
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 9'(i), 1, 0, 0, "t6.frame");
            step(0, 0, 9'h000, 1, 0, 1, "t6.err");
        end
        chk("t6.sat", 32'(err_count), 32'd255);
        step(0, 1, 9'h000, 1, 0, 0, "t6.rearm");
        step(0, 0, 9'h000, 1, 1, 1, "t6.clr_event");
        chk("t6.clr_event", 32'(err_count), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
